// File: rtl/axis_pe_pkg.sv
// rtl/axis_pe_pkg.sv - shared constants and arithmetic helpers for axis_pe_dot
//
// Contents:
//   MODE_BEAT / MODE_PKT : values of the mode input (per-beat / packet accumulate)
//   WIDE_W               : width of the internal headroom used for overflow checks
//   lane_lsb()           : bit offset of a lane operand inside s_axis_tdata
//   fits()               : true when a wide signed value is representable in w bits
//   sat_add()            : signed add clamped to the w-bit signed range
package axis_pe_pkg;

  localparam logic MODE_BEAT = 1'b0;
  localparam logic MODE_PKT  = 1'b1;

  // Accumulator widths up to WIDE_W-1 bits can be added here without the
  // wide sum itself wrapping.
  localparam int WIDE_W = 64;

  // Lane i packs a at [2i*OP_W +: OP_W] and b directly above it.
  function automatic int lane_lsb(input int lane, input int op_w, input bit is_b);
    return (2 * lane + (is_b ? 1 : 0)) * op_w;
  endfunction

  function automatic logic fits(input logic signed [WIDE_W-1:0] x, input int w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (x <= hi) && (x >= lo);
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_add(input logic signed [WIDE_W-1:0] a,
                                                       input logic signed [WIDE_W-1:0] b,
                                                       input int w);
    logic signed [WIDE_W-1:0] s;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/axis_pe_lane_mul.sv
// rtl/axis_pe_lane_mul.sv - one registered signed OP_W x OP_W multiplier lane
//
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the product
//   en_i   : load enable, product register holds when low
//   a_i    : signed operand a
//   b_i    : signed operand b
//   p_o    : registered signed product, 2*OP_W bits (never overflows)
module axis_pe_lane_mul #(
  parameter int OP_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic signed [OP_W-1:0] a_i,
  input  logic signed [OP_W-1:0] b_i,
  output logic signed [2*OP_W-1:0] p_o
);

  logic signed [2*OP_W-1:0] p_d;
  logic signed [2*OP_W-1:0] p_q;

  // Widen both operands first so the multiply is carried out at full width.
  always_comb begin
    p_d = (2*OP_W)'(a_i) * (2*OP_W)'(b_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/axis_pe_dot.sv
// rtl/axis_pe_dot.sv - AXI-Stream dot-product processing element, per-beat or per-packet output
//
// Two pipeline stages: lane products, then lane sum / accumulate into the
// output register. The whole pipeline advances when the output register is
// empty or being taken (adv).
// Optional feature macro: AXIS_PE_SAT_EN (saturating accumulator; default wraps).
//
// Ports:
//   aclk, areset   : clock, asynchronous active-high reset
//   en             : accept enable (pipeline still drains when low)
//   mode           : 0 = one result per beat, 1 = one accumulated result per packet
//   s_axis_*       : input stream, LANES signed (a, b) operand pairs per beat
//   m_axis_*       : output stream, ACC_W-bit signed result
//   ovf            : sticky accumulator overflow, cleared only by reset
module axis_pe_dot
  import axis_pe_pkg::*;
#(
  parameter  int LANES = 2,
  parameter  int OP_W  = 8,
  parameter  int ACC_W = 32,
  localparam int S_W   = 2 * LANES * OP_W
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             en,
  input  logic             mode,
  output logic             s_axis_tready,
  input  logic [S_W-1:0]   s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             m_axis_tready,
  output logic [ACC_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             ovf
);

  localparam int P_W = 2 * OP_W;

  logic adv;
  logic accept;
  logic mode_cur;

  logic in_pkt_q;
  logic mode_pkt_q;
  logic v1_q;
  logic last1_q;
  logic mode1_q;

  logic signed [P_W-1:0]   prod [LANES];
  logic signed [ACC_W-1:0] beat;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [WIDE_W-1:0] sum_w;
  logic                    add_ovf;

  logic [ACC_W-1:0] m_tdata_q;
  logic             m_tvalid_q;
  logic             m_tlast_q;
  logic             ovf_q;

  assign adv           = !m_tvalid_q || m_axis_tready;
  assign s_axis_tready = en && adv && !areset;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // The mode seen by a beat is the live input only on the first beat of a
  // packet; later beats reuse the value latched at packet start.
  assign mode_cur = in_pkt_q ? mode_pkt_q : mode;

  // Stage 1: one registered multiplier per lane, loaded only by accepted beats.
  // The v1 flag below decides whether the product registers carry a real beat.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    axis_pe_lane_mul #(
      .OP_W (OP_W)
    ) u_mul (
      .clk_i (aclk),
      .rst_i (areset),
      .en_i  (accept),
      .a_i   (s_axis_tdata[lane_lsb(i, OP_W, 1'b0) +: OP_W]),
      .b_i   (s_axis_tdata[lane_lsb(i, OP_W, 1'b1) +: OP_W]),
      .p_o   (prod[i])
    );
  end

  always_comb begin
    beat = '0;
    for (int i = 0; i < LANES; i++) begin
      beat = beat + ACC_W'(prod[i]);
    end
  end

  // Accumulate in wide headroom so overflow is visible as an out-of-range sum.
  always_comb begin
    sum_w   = WIDE_W'(acc_q) + WIDE_W'(beat);
    add_ovf = !fits(sum_w, ACC_W);
  end

`ifdef AXIS_PE_SAT_EN
  logic signed [WIDE_W-1:0] sat_w;

  always_comb begin
    sat_w = sat_add(WIDE_W'(acc_q), WIDE_W'(beat), ACC_W);
    acc_d = sat_w[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_d = sum_w[ACC_W-1:0];
  end
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_pkt_q   <= 1'b0;
      mode_pkt_q <= MODE_BEAT;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      mode1_q    <= MODE_BEAT;
      acc_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (accept) begin
        in_pkt_q   <= !s_axis_tlast;
        mode_pkt_q <= mode_cur;
      end
      if (adv) begin
        v1_q    <= accept;
        last1_q <= s_axis_tlast;
        mode1_q <= mode_cur;
        if (v1_q) begin
          if (mode1_q == MODE_BEAT) begin
            m_tdata_q  <= beat;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= last1_q;
          end else begin
            if (add_ovf) begin
              ovf_q <= 1'b1;
            end
            if (last1_q) begin
              m_tdata_q  <= acc_d;
              m_tvalid_q <= 1'b1;
              m_tlast_q  <= 1'b1;
              acc_q      <= '0;
            end else begin
              acc_q      <= acc_d;
              m_tvalid_q <= 1'b0;
            end
          end
        end else begin
          m_tvalid_q <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_axis_pe_dot.sv
// tb/tb_axis_pe_dot.sv - self-checking bench for axis_pe_dot (scoreboard model plus directed literals)
module tb_axis_pe_dot;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        drv_valid = 1'b0;
  logic        sel16 = 1'b0;
  logic        m_tready = 1'b1;

  logic        s_tvalid;
  logic        s_tvalid16;
  logic        s_tready;
  logic        s_tready16;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        ovf;
  logic [15:0] m16_tdata;
  logic        m16_tvalid;
  logic        m16_tlast;
  logic        ovf16;

  assign s_tvalid   = drv_valid && !sel16;
  assign s_tvalid16 = drv_valid && sel16;

  always #5 aclk = ~aclk;

  axis_pe_dot #(.LANES(2), .OP_W(8), .ACC_W(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .en            (en),
    .mode          (mode),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .ovf           (ovf)
  );

  axis_pe_dot #(.LANES(2), .OP_W(8), .ACC_W(16)) dut16 (
    .aclk          (aclk),
    .areset        (areset),
    .en            (en),
    .mode          (mode),
    .s_axis_tready (s_tready16),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid16),
    .s_axis_tlast  (s_tlast),
    .m_axis_tready (1'b1),
    .m_axis_tdata  (m16_tdata),
    .m_axis_tvalid (m16_tvalid),
    .m_axis_tlast  (m16_tlast),
    .ovf           (ovf16)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  typedef struct {
    longint data;
    bit     last;
    int     cyc;
  } out_t;

  out_t   exp_q[$];
  out_t   log_q[$];
  int     acc_cyc_q[$];
  longint m_acc = 0;
  bit     m_in_pkt = 1'b0;
  bit     m_mode = 1'b0;
  bit     hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  bit     rand_done = 1'b0;

  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: plain signed arithmetic over the packed lanes.
  function automatic longint dot(input logic [31:0] d);
    longint s = 0;
    for (int i = 0; i < 2; i++) begin
      s += longint'($signed(d[2*i*8 +: 8])) * longint'($signed(d[(2*i+1)*8 +: 8]));
    end
    return s;
  endfunction

  function automatic longint acc_add(input longint a, input longint b);
    longint s;
    s = a + b;
`ifdef AXIS_PE_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
    s = longint'($signed(s[31:0]));
`endif
    return s;
  endfunction

  // Scoreboard and model, evaluated away from the active edge.
  always @(negedge aclk) begin
    out_t   e;
    longint d;
    if (areset) begin
      exp_q.delete();
      acc_cyc_q.delete();
      m_acc     = 0;
      m_in_pkt  = 1'b0;
      m_mode    = 1'b0;
      hold_pend = 1'b0;
    end else begin
      chk("s_tready", longint'(s_tready), longint'(en && (!m_tvalid || m_tready)));
      if (m_tvalid) begin
        if (hold_pend) begin
          chk("hold_data", longint'(m_tdata), longint'(hold_data));
          chk("hold_last", longint'(m_tlast), longint'(hold_last));
        end
        if (m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got data %0d, none expected", $signed(m_tdata));
          end else begin
            e = exp_q.pop_front();
            chk("out_data", longint'($signed(m_tdata)), e.data);
            chk("out_last", longint'(m_tlast), longint'(e.last));
          end
          log_q.push_back('{longint'($signed(m_tdata)), bit'(m_tlast), cyc});
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          hold_data = m_tdata;
          hold_last = m_tlast;
        end
      end else if (hold_pend) begin
        checks++;
        $display("FAIL valid_dropped: got tvalid 0 required 1 while stalled");
        hold_pend = 1'b0;
      end

      if (s_tvalid && s_tready) begin
        d = dot(s_tdata);
        acc_cyc_q.push_back(cyc);
        if (!m_in_pkt) m_mode = mode;
        m_in_pkt = !s_tlast;
        if (!m_mode) begin
          exp_q.push_back('{d, bit'(s_tlast), 0});
        end else begin
          m_acc = acc_add(m_acc, d);
          if (s_tlast) begin
            exp_q.push_back('{m_acc, 1'b1, 0});
            m_acc = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    s_tdata   = d;
    s_tlast   = l;
    drv_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge aclk);
      if (sel16 ? s_tready16 : s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: got no tready required tready within 300 cycles");
    end
    @(posedge aclk);
    #1;
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending results required 0", exp_q.size());
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1);
  end

  initial begin
    bit          got16;
    logic [15:0] d16;
    int          len;

    // Model pins.
    chk("model_dot_pos", dot(32'h00010801), 64'sd8);
    chk("model_dot_neg", dot(32'h000002FF), -64'sd2);
    chk("model_dot_max", dot(32'h7F7F7F7F), 64'sd32258);
`ifdef AXIS_PE_SAT_EN
    chk("model_acc_edge", acc_add(64'sd2147483647, 64'sd1), 64'sd2147483647);
`else
    chk("model_acc_edge", acc_add(64'sd2147483647, 64'sd1), -64'sd2147483648);
`endif

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready", longint'(s_tready), 0);
    chk("rst_m_tvalid", longint'(m_tvalid), 0);
    chk("rst_m_tdata", longint'(m_tdata), 0);
    chk("rst_m_tlast", longint'(m_tlast), 0);
    chk("rst_ovf", longint'(ovf), 0);
    areset = 1'b0;
    en     = 1'b1;
    @(posedge aclk);
    #1;

    // 1: per-beat results and latency.
    mode = 1'b0;
    log_q.delete();
    acc_cyc_q.delete();
    send(32'h00010801, 1'b0);
    send(32'h00020702, 1'b0);
    send(32'h00030603, 1'b1);
    drain();
    chk("t1_count", log_q.size(), 3);
    if (log_q.size() == 3 && acc_cyc_q.size() == 3) begin
      chk("t1_d0", log_q[0].data, 8);
      chk("t1_d1", log_q[1].data, 14);
      chk("t1_d2", log_q[2].data, 18);
      chk("t1_l0", longint'(log_q[0].last), 0);
      chk("t1_l1", longint'(log_q[1].last), 0);
      chk("t1_l2", longint'(log_q[2].last), 1);
      for (int i = 0; i < 3; i++) chk("t1_latency", log_q[i].cyc - acc_cyc_q[i], 2);
    end

    // 2: packet accumulate, twice to show the accumulator clears.
    mode = 1'b1;
    log_q.delete();
    for (int p = 0; p < 2; p++) begin
      send(32'h00010801, 1'b0);
      send(32'h00020702, 1'b0);
      send(32'h00030603, 1'b1);
    end
    drain();
    chk("t2_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_d0", log_q[0].data, 40);
      chk("t2_l0", longint'(log_q[0].last), 1);
      chk("t2_d1", log_q[1].data, 40);
    end

    // 3: signed operands.
    mode = 1'b0;
    log_q.delete();
    send(32'h0000FFFF, 1'b0);
    send(32'h000002FF, 1'b1);
    drain();
    chk("t3_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t3_d0", log_q[0].data, 1);
      chk("t3_d1", log_q[1].data, -2);
    end

    // 4: 16-bit accumulator overflow on the narrow instance.
    sel16 = 1'b1;
    mode  = 1'b1;
    send(32'h00007F7F, 1'b0);
    send(32'h00007F7F, 1'b0);
    send(32'h00007F7F, 1'b1);
    got16 = 1'b0;
    d16   = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge aclk);
      if (m16_tvalid) begin
        got16 = 1'b1;
        d16   = m16_tdata;
        chk("t4_last", longint'(m16_tlast), 1);
        break;
      end
    end
    chk("t4_got", longint'(got16), 1);
`ifdef AXIS_PE_SAT_EN
    chk("t4_data", longint'(d16), 64'h7FFF);
`else
    chk("t4_data", longint'(d16), 64'hBD03);
`endif
    chk("t4_ovf16", longint'(ovf16), 1);
    chk("t4_ovf_main", longint'(ovf), 0);
    sel16 = 1'b0;
    @(posedge aclk);
    #1;

    // 5: output backpressure while streaming.
    mode = 1'b0;
    log_q.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) send($urandom, i == 11);
      end
      begin
        repeat (3) @(posedge aclk);
        #1;
        m_tready = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    chk("t5_count", log_q.size(), 12);

    // 6: reset mid-packet discards the partial sum.
    mode = 1'b1;
    send(32'h00010801, 1'b0);
    send(32'h00020702, 1'b0);
    areset = 1'b1;
    #1;
    chk("t6_m_tvalid", longint'(m_tvalid), 0);
    chk("t6_m_tdata", longint'(m_tdata), 0);
    chk("t6_m_tlast", longint'(m_tlast), 0);
    chk("t6_ovf16", longint'(ovf16), 0);
    chk("t6_s_tready", longint'(s_tready), 0);
    @(negedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    log_q.delete();
    send(32'h00030603, 1'b1);
    drain();
    chk("t6_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t6_d0", log_q[0].data, 18);
      chk("t6_l0", longint'(log_q[0].last), 1);
    end

    // Random traffic: random packets, gaps, en, mode toggles and backpressure.
    fork
      begin
        while (!rand_done) begin
          @(posedge aclk);
          #1;
          en       = ($urandom_range(0, 9) < 8);
          mode     = 1'($urandom_range(0, 1));
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int p = 0; p < 60; p++) begin
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 2) == 0) begin
              @(posedge aclk);
              #1;
            end
            send($urandom, b == len - 1);
          end
        end
        rand_done = 1'b1;
      end
    join
    @(posedge aclk);
    #1;
    en       = 1'b1;
    m_tready = 1'b1;
    drain();
    chk("rand_pending", exp_q.size(), 0);
    chk("rand_ovf", longint'(ovf), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
